// File: rtl/systolic_2x2_collect.sv
`default_nettype none
// ============================================================================
// Module      : systolic_2x2_collect
// Description : Output collector for a 2x2 weight-stationary systolic array.
//               A delayed copy of the array's input-row valid marks when each
//               column result arrives. Col0 is held in a skew line until its
//               col1 partner appears. The aligned row is then written with a
//               matrix-row parity bit into a show-ahead FIFO, which is read
//               out over valid/ready.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid            - row entered the array this cycle
//               c_col0_in/c_col1_in - skewed signed column results
//               out_valid/out_ready - downstream handshake
//               out_c0/out_c1       - head row data
//               out_last            - head row is the second row of a matrix
//               count               - FIFO occupancy
//               overflow            - sticky, a row was dropped on full
// Options     : SYS2X2_COLLECT_RELU_EN - clamp negative values to 0 at write
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_2x2_collect #(
    parameter int C_W   = 8,
    parameter int LAT0  = 2,
    parameter int SKEW  = 1,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [C_W-1:0]       c_col0_in,
    input  logic signed [C_W-1:0]       c_col1_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [C_W-1:0]       out_c0,
    output logic signed [C_W-1:0]       out_c1,
    output logic                        out_last,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow
);

    localparam int c_VLEN = LAT0 + SKEW;
    localparam int c_AW   = $clog2(DEPTH);
    localparam int c_CW   = c_AW + 1;

    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE   = 1;
    localparam logic [c_AW-1:0] c_PTR_ONE   = 1;

    // Valid delay line; bit k is in_valid delayed by k+1 cycles, so the value
    // seen at a clock edge by bit D-1 is the in_valid sampled D edges earlier.
    logic [c_VLEN-1:0]     r_vline_q;
    // Free-running col0 skew line; its oldest stage is the col0 partner of the
    // current col1 whenever the col1 tap is set. No explicit col0 tap is needed.
    logic signed [C_W-1:0] r_c0line_q [SKEW];

    logic signed [C_W-1:0] r_mem_c0_q   [DEPTH];
    logic signed [C_W-1:0] r_mem_c1_q   [DEPTH];
    logic                  r_mem_last_q [DEPTH];

    logic [c_AW-1:0]       r_wr_ptr_q;
    logic [c_AW-1:0]       r_rd_ptr_q;
    logic [c_CW-1:0]       r_count_q;
    logic [c_CW-1:0]       w_count_d;
    logic                  r_parity_q;
    logic                  r_overflow_q;

    logic                  w_v1;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic signed [C_W-1:0] w_c0_aligned;
    logic signed [C_W-1:0] w_wr_c0;
    logic signed [C_W-1:0] w_wr_c1;

    assign w_v1         = r_vline_q[c_VLEN-1];
    assign w_c0_aligned = r_c0line_q[SKEW-1];

    assign w_full = (r_count_q == c_DEPTH_CNT);
    assign w_pop  = out_valid && out_ready;
    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    assign w_push = w_v1 && (!w_full || w_pop);

`ifdef SYS2X2_COLLECT_RELU_EN
    assign w_wr_c0 = w_c0_aligned[C_W-1] ? '0 : w_c0_aligned;
    assign w_wr_c1 = c_col1_in[C_W-1]    ? '0 : c_col1_in;
`else
    assign w_wr_c0 = w_c0_aligned;
    assign w_wr_c1 = c_col1_in;
`endif

    always_comb begin
        w_count_d = r_count_q;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_ONE;
            2'b01:   w_count_d = r_count_q - c_CNT_ONE;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vline_q    <= '0;
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_count_q    <= '0;
            r_parity_q   <= 1'b0;
            r_overflow_q <= 1'b0;
            for (int i = 0; i < SKEW; i++) begin
                r_c0line_q[i] <= '0;
            end
            // Storage is cleared so the head outputs read 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_c0_q[i]   <= '0;
                r_mem_c1_q[i]   <= '0;
                r_mem_last_q[i] <= 1'b0;
            end
        end else begin
            r_vline_q     <= {r_vline_q[c_VLEN-2:0], in_valid};
            r_c0line_q[0] <= c_col0_in;
            for (int i = 1; i < SKEW; i++) begin
                r_c0line_q[i] <= r_c0line_q[i-1];
            end

            // Parity advances on every arriving row, dropped or not, so
            // matrix framing stays correct after an overflow.
            if (w_v1) begin
                r_parity_q <= ~r_parity_q;
                if (!w_push) begin
                    r_overflow_q <= 1'b1;
                end
            end

            if (w_push) begin
                r_mem_c0_q[r_wr_ptr_q]   <= w_wr_c0;
                r_mem_c1_q[r_wr_ptr_q]   <= w_wr_c1;
                r_mem_last_q[r_wr_ptr_q] <= r_parity_q;
                r_wr_ptr_q               <= r_wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr_q <= r_rd_ptr_q + c_PTR_ONE;
            end
            r_count_q <= w_count_d;
        end
    end

    assign out_valid = (r_count_q != '0);
    assign out_c0    = r_mem_c0_q[r_rd_ptr_q];
    assign out_c1    = r_mem_c1_q[r_rd_ptr_q];
    assign out_last  = r_mem_last_q[r_rd_ptr_q];
    assign count     = r_count_q;
    assign overflow  = r_overflow_q;

endmodule
`default_nettype wire

// File: doc/systolic_2x2_collect.md
# systolic_2x2_collect

Output collector for the 2x2 weight-stationary systolic array. Consumes the column-skewed result streams `c_col0_out` and `c_col1_out`, using a valid token that travels alongside the array's input rows. Re-aligns each result row so both columns appear in one beat, buffers rows in a small FIFO, and presents them downstream over a valid/ready handshake with matrix framing (`out_last`).

## Interface
Parameters:
- `C_W`, 8: result width, signed; matches the array's `C_W`.
- `LAT0`, 2: cycles from an input row being sampled by the array (`in_valid` high at a posedge) to its col0 result being sampled here. Must be ≥ 1.
- `SKEW`, 1: extra cycles col1 lags col0. Must be ≥ 1.
- `DEPTH`, 4: FIFO depth in row entries. Power of 2, ≥ 2.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: high in the same cycle a valid row is driven on the array's `a_row0_in`/`a_row1_in`.
- `c_col0_in`, input, C_W signed: array `c_col0_out`.
- `c_col1_in`, input, C_W signed: array `c_col1_out`.
- `out_valid`, output, 1: FIFO head is valid.
- `out_ready`, input, 1: downstream accepts the head.
- `out_c0`, output, C_W signed: head row, column 0.
- `out_c1`, output, C_W signed: head row, column 1.
- `out_last`, output, 1: head is row 1 (second row) of a matrix.
- `count`, output, $clog2(DEPTH)+1: number of occupied entries.
- `overflow`, output, 1: sticky; set when a row is dropped because the FIFO is full.

## Operation
- **Valid delay line.** A shift register of length `LAT0+SKEW` carries `in_valid`.
  - Tap `v0` is at delay `LAT0`.
  - Tap `v1` is at delay `LAT0+SKEW`.
- **Col0 skew line.** A `SKEW`-deep shift register advances every cycle and loads `c_col0_in`. Back-to-back rows are therefore handled without bubbles. When `v1` is high, the oldest entry of this line is the col0 result paired with the current `c_col1_in`.
- **Write.** When `v1` is high, `{col0_aligned, c_col1_in, parity}` is written at the FIFO tail.
- **Parity.** A 1-bit register, reset to 0, that toggles on every `v1`, including dropped writes, so matrix framing survives an overflow. The stored `last` bit equals parity before the toggle.
- **Read.** Show-ahead FIFO: `out_*` always reflect the head entry. A pop occurs on `out_valid && out_ready`.
- **Full.** A write when `count==DEPTH` and no pop in the same cycle is dropped. `overflow` is set and remains set until `rst`.
- **Full with simultaneous pop.** The write succeeds and `count` is unchanged.
- **Empty with simultaneous write.** `out_valid` rises the next cycle. There is no bypass.
- **Empty.** `out_valid=0`. `out_c0`, `out_c1` and `out_last` are don't-care; implement them as the registered head value.
- **Pointers.** Wrap modulo `DEPTH`. Full and empty are distinguished by `count`.
- **Arithmetic.** None beyond optional ReLU. Values are passed through bit-exact in `C_W`.

## Timing
- **Reset values.** `rst` sampled high at a posedge clears the valid line, the col0 line, the pointers, `count`, parity and `overflow`. After that edge:
  - `out_valid=0`
  - `out_c0=0`, `out_c1=0`
  - `out_last=0`
  - `count=0`
  - `overflow=0`
- **Reset mid-operation.** In-flight rows are discarded and no partial entry is written.
- **Latency.** With `in_valid` sampled high at posedge t:
  - col0 is captured at t+LAT0.
  - col1 is captured and the write occurs at t+LAT0+SKEW.
  - `out_valid` is high after that edge if the FIFO was empty.
- **Throughput.** One row per cycle sustained while `out_ready=1`.
- **Handshake.** `out_valid` must not drop and `out_*` must not change until a pop occurs. `out_ready` may toggle freely.

## Configuration
- **Macro:** `SYS2X2_COLLECT_RELU_EN`.
- **Defined:** at FIFO write, each column value less than 0 is replaced with 0. This is an activation stage.
- **Undefined:** values are stored unmodified, including negatives.
- The macro has no timing impact in either case.

## Test plan
All scenarios use a behavioural array model with W=[[1,2],[3,4]], LAT0=2, SKEW=1, DEPTH=4.

- **Reset.** Assert `rst` for 3 cycles, then release with `in_valid=0` → `out_valid=0`, `count=0`, `overflow=0` for 10 cycles.
- **Single matrix.** Rows [1,0] then [2,1] back-to-back, `out_ready=1` → beats (1,2,last=0) then (5,8,last=1). The first beat has `out_valid` high 3 cycles after the first `in_valid` edge.
- **Signed matrix.** Rows [-1,2] then [3,-2] → (5,6,0) then (-3,-2,1) without ReLU, and (5,6,0) then (0,0,1) with `SYS2X2_COLLECT_RELU_EN`.
- **Backpressure and overflow.** `out_ready=0` while 5 matrices (10 rows) stream in → `count` saturates at 4 and `overflow=1`. After releasing `out_ready`, the first 4 rows of matrix 0 and matrix 1 emerge in order with correct `last` bits.
- **Full with simultaneous pop.** FIFO full, `out_ready=1` in the same cycle as a write → no drop, `count` stays at 4, `overflow` stays 0.
- **Reset mid-stream.** Assert `rst` one cycle after the second row of a matrix enters the array → no output beat from that matrix. Parity restarts at 0, so the next matrix's first row has `last=0`.
